// File: rtl/sram_pm_wrapper.sv
// Single-port SRAM wrapper: byte-enable writes, grant/valid handshake, optional output
// register and a retention sequencer (ACTIVE -> DRAIN -> RETENTIVE -> WAKE -> ACTIVE).
module sram_pm_wrapper #(
  parameter int unsigned NumWords     = 1024,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned OutputReg    = 0,
  parameter int unsigned WakeupCycles = 4,
  parameter int unsigned AddrWidth    = $clog2(NumWords),
  parameter int unsigned BeWidth      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  input  logic                 set_retentive_i,
  output logic                 retentive_o
);

  localparam int unsigned CntWidth = (WakeupCycles > 32'd1) ? $clog2(WakeupCycles) : 32'd1;
  localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WakeupCycles - 32'd1);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_RETENTIVE = 2'd2,
    ST_WAKE      = 2'd3
  } state_e;

  state_e               state_r;
  state_e               state_next_s;
  logic [CntWidth-1:0]  cnt_r;
  logic [CntWidth-1:0]  cnt_next_s;
  logic                 retentive_r;
  logic                 gnt_s;
  logic                 oor_s;
  logic                 drained_s;
  logic [DataWidth-1:0] mem_r [NumWords];
  logic                 s1_valid_r;
  logic                 s1_err_r;
  logic [DataWidth-1:0] s1_data_r;

  assign oor_s       = ({1'b0, addr_i} >= (AddrWidth + 32'd1)'(NumWords));
  assign gnt_s       = req_i & ~rst_i & ~set_retentive_i & (state_r == ST_ACTIVE);
  assign gnt_o       = gnt_s;
  assign retentive_o = retentive_r;
  // Without the output register the array access is finished at the grant edge.
  assign drained_s   = (OutputReg == 32'd0) | ~s1_valid_r;

  // Power-management next-state and wake counter.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_ACTIVE: begin
        if (set_retentive_i) state_next_s = ST_DRAIN;
        else                 state_next_s = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (!set_retentive_i) state_next_s = ST_ACTIVE;
        else if (drained_s)   state_next_s = ST_RETENTIVE;
        else                  state_next_s = ST_DRAIN;
      end
      ST_RETENTIVE: begin
        if (!set_retentive_i) begin
          state_next_s = ST_WAKE;
          cnt_next_s   = WakeLoad;
        end else begin
          state_next_s = ST_RETENTIVE;
        end
      end
      ST_WAKE: begin
        if (cnt_r == {CntWidth{1'b0}}) state_next_s = ST_ACTIVE;
        else                           cnt_next_s   = cnt_r - CntWidth'(1);
      end
      default: begin
        state_next_s = ST_ACTIVE;
        cnt_next_s   = {CntWidth{1'b0}};
      end
    endcase
  end

  // State register; retentive flag follows the state one edge later than DRAIN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_ACTIVE;
      cnt_r       <= {CntWidth{1'b0}};
      retentive_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      retentive_r <= (state_next_s == ST_RETENTIVE);
    end
  end

  // Storage array; deliberately not reset so contents survive reset and retention.
  always_ff @(posedge clk_i) begin
    if (gnt_s && we_i && !oor_s) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (be_i[b]) mem_r[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // First response stage; read data only moves on reads so it holds across writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_r <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_data_r  <= {DataWidth{1'b0}};
    end else begin
      s1_valid_r <= gnt_s;
      s1_err_r   <= gnt_s & oor_s;
      if (gnt_s && !we_i) s1_data_r <= oor_s ? {DataWidth{1'b0}} : mem_r[addr_i];
    end
  end

  if (OutputReg == 32'd0) begin : g_direct
    // A completion coinciding with reset is discarded.
    assign rvalid_o = s1_valid_r & ~rst_i;
    assign err_o    = s1_err_r & ~rst_i;
    assign rdata_o  = s1_data_r;
  end else begin : g_oreg
    logic                 s1_read_r;
    logic                 s2_valid_r;
    logic                 s2_err_r;
    logic [DataWidth-1:0] s2_data_r;

    // Second response stage.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_read_r  <= 1'b0;
        s2_valid_r <= 1'b0;
        s2_err_r   <= 1'b0;
        s2_data_r  <= {DataWidth{1'b0}};
      end else begin
        s1_read_r  <= gnt_s & ~we_i;
        s2_valid_r <= s1_valid_r;
        s2_err_r   <= s1_err_r;
        if (s1_read_r) s2_data_r <= s1_data_r;
      end
    end

    assign rvalid_o = s2_valid_r & ~rst_i;
    assign err_o    = s2_err_r & ~rst_i;
    assign rdata_o  = s2_data_r;
  end

endmodule

// File: tb/tb_sram_pm_wrapper.sv
// Scoreboard bench: two wrappers (direct and registered output) share one random
// stimulus stream and are checked against a transaction-level memory/power model.
module tb_sram_pm_wrapper;
  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int BW   = 4;
  localparam int WAKE = 4;
  localparam int NW0  = 1000;
  localparam int NW1  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic          set_ret = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be = '0;
  logic [1:0]    gnt, rvalid, err, ret;
  logic [DW-1:0] rdata [2];

  always #5 clk = ~clk;

  sram_pm_wrapper #(.NumWords(NW0), .DataWidth(DW), .OutputReg(0), .WakeupCycles(WAKE)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[0]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .set_retentive_i(set_ret), .retentive_o(ret[0]));

  sram_pm_wrapper #(.NumWords(NW1), .DataWidth(DW), .OutputReg(1), .WakeupCycles(WAKE)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[1]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .set_retentive_i(set_ret), .retentive_o(ret[1]));

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef enum {P_ACTIVE, P_DRAIN, P_RET, P_WAKE} phase_e;

  exp_t        sb [2][$];
  phase_e      phase [2] = '{P_ACTIVE, P_ACTIVE};
  logic [31:0] ref_mem [2][1024];
  int          last_due [2] = '{-10, -10};
  int          wake_until [2] = '{0, 0};
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] cyc=%0d got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  // Reference model: evaluated on each active edge using the inputs of the ending cycle.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int   nw;
      nw = (k == 0) ? NW0 : NW1;
      if (rst) begin
        sb[k].delete();
        phase[k]    = P_ACTIVE;
        last_due[k] = -10;
        last_rd[k]  = 32'd0;
      end else begin
        if (req && !set_ret && phase[k] == P_ACTIVE) begin
          e.due = cyc + k + 1;
          e.err = (int'(addr) >= nw);
          if (we) begin
            if (!e.err)
              for (int b = 0; b < BW; b++)
                if (be[b]) ref_mem[k][addr][8*b +: 8] = wdata[8*b +: 8];
            e.data = last_rd[k];
          end else begin
            e.data = e.err ? 32'd0 : ref_mem[k][addr];
            last_rd[k] = e.data;
          end
          sb[k].push_back(e);
          last_due[k] = e.due;
        end
        case (phase[k])
          P_ACTIVE: if (set_ret) phase[k] = P_DRAIN;
          P_DRAIN: begin
            if (!set_ret) phase[k] = P_ACTIVE;
            else if (last_due[k] < cyc + 1) phase[k] = P_RET;
          end
          P_RET: if (!set_ret) begin
            phase[k]      = P_WAKE;
            wake_until[k] = cyc + 1 + WAKE;
          end
          default: if (cyc + 1 >= wake_until[k]) phase[k] = P_ACTIVE;
        endcase
      end
    end
    cyc++;
  end

  // Monitor: compares handshake, retention flag and completions mid-cycle.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      chk("gnt", k, gnt[k], req && !set_ret && !rst && phase[k] == P_ACTIVE);
      chk("retentive", k, ret[k], phase[k] == P_RET);
      if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
        e = sb[k].pop_front();
        if (rst) begin
          chk("rvalid_in_reset", k, rvalid[k], 1'b0);
        end else begin
          chk("rvalid", k, rvalid[k], 1'b1);
          chk("rdata", k, rdata[k], e.data);
          chk("err", k, err[k], e.err);
        end
      end else begin
        chk("rvalid_idle", k, rvalid[k], 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic w, input int a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = AW'(a); wdata = d; be = b;
    step();
    req = 1'b0;
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 15));
    return int'($urandom_range(996, 1023));
  endfunction

  initial begin
    int n;
    int ret_hold;
    ret_hold = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", k, rdata[k], 32'd0);
      chk("reset_err", k, err[k], 1'b0);
    end
    step();

    acc(1'b1, 5, 32'hDEADBEEF, 4'hF);
    acc(1'b0, 5, 32'h0, 4'h0);
    acc(1'b1, 5, 32'h11223344, 4'h5);
    acc(1'b0, 5, 32'h0, 4'h0);
    acc(1'b1, 5, 32'hFFFFFFFF, 4'h0);
    acc(1'b0, 5, 32'h0, 4'h0);
    repeat (3) step();

    for (int a = 0; a < 16; a++) if (a != 5) acc(1'b1, a, $urandom, 4'hF);
    for (int a = 996; a < 1024; a++) acc(1'b1, a, $urandom, 4'hF);
    for (int a = 0; a < 4; a++) acc(1'b0, a, 32'h0, 4'h0);
    acc(1'b0, 1010, 32'h0, 4'h0);
    acc(1'b1, 1010, 32'hA5A5A5A5, 4'hF);
    acc(1'b0, 1010, 32'h0, 4'h0);
    acc(1'b0, 10, 32'h0, 4'h0);
    repeat (3) step();

    // Retention with a request held across entry.
    acc(1'b1, 7, 32'hC0FFEE07, 4'hF);
    req = 1'b1; we = 1'b0; addr = AW'(7);
    step();
    set_ret = 1'b1;
    n = 0;
    @(negedge clk);
    while (ret[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("entry_latency", 0, n, 2);
    n = 0;
    while (ret[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("entry_timeout", 1, ret[1], 1'b1);
    @(posedge clk); #1;
    repeat (3) step();
    set_ret = 1'b0;
    n = 0;
    @(negedge clk);
    while (gnt[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("exit_latency", 0, n, 1 + WAKE);
    chk("exit_gnt", 1, gnt[1], 1'b1);
    @(posedge clk); #1;
    repeat (2) step();
    req = 1'b0;
    repeat (3) step();

    // Reset the cycle after a read grant.
    acc(1'b0, 5, 32'h0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    acc(1'b0, 5, 32'h0, 4'h0);
    acc(1'b0, 7, 32'h0, 4'h0);
    repeat (3) step();

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (ret_hold > 0) begin
        set_ret = 1'b1;
        ret_hold--;
      end else begin
        set_ret = 1'b0;
        if ($urandom_range(0, 39) == 0) ret_hold = int'($urandom_range(1, 14));
      end
      req   = ($urandom_range(0, 9) < 7);
      we    = $urandom_range(0, 1) == 1;
      addr  = AW'(pick_addr());
      wdata = $urandom;
      be    = BW'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; set_ret = 1'b0; req = 1'b0;
    repeat (12) step();
    for (int k = 0; k < 2; k++) chk("pending_completions", k, sb[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
